hamming_tx: RTL and testbench

Streaming (7,4) Hamming encoder and serializer for the transmit side of the link. It accepts a word of NIBBLES 4-bit nibbles over a valid/ready handshake and encodes each nibble into a 7-bit codeword. The codewords are shifted out one bit per beat on a valid/ready serial interface. Its parity equations give a zero syndrome in the team's (7,4) single-error-correcting decoder.

---
 rtl/hamming_pkg.sv | 13 +
 rtl/hamming74_enc_core.sv | 15 +
 rtl/hamming_tx.sv | 95 +++++++++
 tb/tb_hamming_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg: shared (7,4) Hamming constants and the transmit FSM state type.
package hamming_pkg;
    localparam int CW_W = 7;
    localparam int NIB_W = 4;
    // Parity bit positions and the data bits each one covers; the decoder uses the same set.
    localparam int P0_IDX = 4;
    localparam int P1_IDX = 5;
    localparam int P2_IDX = 6;
    localparam logic [NIB_W-1:0] P0_MASK = 4'b0111;
    localparam logic [NIB_W-1:0] P1_MASK = 4'b1101;
    localparam logic [NIB_W-1:0] P2_MASK = 4'b1011;
    typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/hamming74_enc_core.sv
// hamming74_enc_core: combinational (7,4) encoder, data in c[3:0], parity in c[6:4].
module hamming74_enc_core
    import hamming_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    output logic [CW_W-1:0]  o_cw
);
    always_comb begin
        o_cw = '0;
        o_cw[NIB_W-1:0] = i_nib;
        o_cw[P0_IDX] = ^(i_nib & P0_MASK);
        o_cw[P1_IDX] = ^(i_nib & P1_MASK);
        o_cw[P2_IDX] = ^(i_nib & P2_MASK);
    end
endmodule

// File: rtl/hamming_tx.sv
// hamming_tx: encodes a word of nibbles into (7,4) codewords and serializes them LSB first.
module hamming_tx
    import hamming_pkg::*;
#(
    parameter int NIBBLES = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NIB_W*NIBBLES-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     tx_bit,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     tx_sof,
    output logic                     tx_eof,
    output logic [CNT_W-1:0]         cw_count,
    output logic                     busy
);
    localparam int FRAME_W = CW_W * NIBBLES;
    localparam int IDX_W = $clog2(FRAME_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

    state_t             r_state, w_state_nxt;
    logic [FRAME_W-1:0] r_shift, w_shift_nxt, w_cws;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [2:0]         r_sub, w_sub_nxt;
    logic               r_sof, w_sof_nxt, r_eof, w_eof_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_load, w_beat, w_cw_done;

    for (genvar k = 0; k < NIBBLES; k++) begin : g_enc
        hamming74_enc_core u_enc (
            .i_nib(in_data[NIB_W*k +: NIB_W]),
            .o_cw (w_cws[CW_W*k +: CW_W])
        );
    end

    assign tx_valid = (r_state == SHIFT);
    assign busy = tx_valid;
    assign tx_bit = r_shift[0];
    assign tx_sof = r_sof;
    assign tx_eof = r_eof;
    assign cw_count = r_cnt;
    // Accepting on the eof beat lets the next frame follow with no idle cycle.
    assign in_ready = !rst && (r_state == IDLE || (r_eof && tx_ready));
    assign w_load = in_valid && in_ready;
    assign w_beat = tx_valid && tx_ready;
    assign w_cw_done = w_beat && (r_sub == 3'd6);

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt = r_idx;
        w_sub_nxt = r_sub;
        w_sof_nxt = r_sof;
        w_eof_nxt = r_eof;
        if (w_load) begin
            w_state_nxt = SHIFT;
            w_shift_nxt = w_cws;
            w_idx_nxt = '0;
            w_sub_nxt = '0;
            w_sof_nxt = 1'b1;
            w_eof_nxt = 1'b0;
        end else if (w_beat) begin
            w_state_nxt = r_eof ? IDLE : SHIFT;
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt = r_eof ? '0 : r_idx + IDX_W'(1);
            w_sub_nxt = (r_sub == 3'd6) ? 3'd0 : r_sub + 3'd1;
            w_sof_nxt = 1'b0;
            w_eof_nxt = !r_eof && (r_idx + IDX_W'(1) == LAST_IDX);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx <= '0;
            r_sub <= '0;
            r_sof <= 1'b0;
            r_eof <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx <= w_idx_nxt;
            r_sub <= w_sub_nxt;
            r_sof <= w_sof_nxt;
            r_eof <= w_eof_nxt;
            if (w_cw_done) r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hamming_tx.sv
// tb_hamming_tx: scoreboard bench for hamming_tx with an independent encoder/decoder model.
module tb_hamming_tx;
    localparam int NIB = 2;
    localparam int CW = 4;
    localparam int FW = 7 * NIB;

    logic            clk, rst;
    logic [4*NIB-1:0] in_data;
    logic            in_valid, in_ready, tx_bit, tx_valid, tx_ready, tx_sof, tx_eof, busy;
    logic [CW-1:0]   cw_count;

    hamming_tx #(.NIBBLES(NIB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sof(tx_sof),
        .tx_eof(tx_eof), .cw_count(cw_count), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int mode = 0;
    int ph = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[0]^d[1]^d[3], d[0]^d[2]^d[3], d[0]^d[1]^d[2], d};
    endfunction

    function automatic logic [3:0] dec(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] m, f;
        s = {c[6]^c[0]^c[1]^c[3], c[5]^c[0]^c[2]^c[3], c[4]^c[0]^c[1]^c[2]};
        case (s)
            3'd7: m = 7'h01;
            3'd5: m = 7'h02;
            3'd3: m = 7'h04;
            3'd6: m = 7'h08;
            3'd1: m = 7'h10;
            3'd2: m = 7'h20;
            3'd4: m = 7'h40;
            default: m = 7'h00;
        endcase
        f = c ^ m;
        return f[3:0];
    endfunction

    // Entry: {nibble[7:4], codeword end, eof, sof, bit}
    logic [7:0]    sb[$];
    logic [7:0]    e;
    logic [CW-1:0] exp_cw;
    logic [6:0]    rx_cw, rc;
    logic [FW-1:0] rx_frame, rx_last;
    int            rx_sub, rx_pos;
    logic          prev_stall;
    logic [3:0]    prev_out;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_cw = '0;
            rx_sub = 0;
            rx_pos = 0;
            prev_stall = 0;
        end else begin
            chk("cw_count", cw_count, exp_cw);
            chk("busy", busy, tx_valid);
            if (prev_stall) chk("stall", {tx_valid, tx_sof, tx_eof, tx_bit}, prev_out);
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("beat", {tx_eof, tx_sof, tx_bit}, e[2:0]);
                    if (e[1]) rx_pos = 0;
                    rx_frame[rx_pos] = tx_bit;
                    rx_pos++;
                    rx_cw[rx_sub] = tx_bit;
                    if (e[3]) begin
                        rc = rx_cw ^ (7'h01 << $urandom_range(0, 6));
                        chk("roundtrip", dec(rc), e[7:4]);
                        exp_cw = exp_cw + 1'b1;
                        rx_sub = 0;
                    end else rx_sub++;
                    if (e[2]) rx_last = rx_frame;
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < NIB; k++) begin
                    logic [3:0] d;
                    logic [6:0] c;
                    d = in_data[4*k +: 4];
                    c = enc(d);
                    for (int j = 0; j < 7; j++)
                        sb.push_back({d, j == 6, 7*k + j == FW - 1, k == 0 && j == 0, c[j]});
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_out = {tx_valid, tx_sof, tx_eof, tx_bit};
        end
    end

    initial begin
        tx_ready = 1;
        forever begin
            @(posedge clk); #1;
            ph = (ph + 1) % 3;
            tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (ph == 0) : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [4*NIB-1:0] w);
        in_data = w;
        in_valid = 1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 0;
                @(negedge clk);
                chk("sof_latency", {tx_valid, tx_sof}, 2'b11);
                @(posedge clk); #1;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (!tx_valid && sb.size() == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("idle_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outputs", {tx_valid, tx_bit, tx_sof, tx_eof, busy}, 0);
        chk("reset_cw_count", cw_count, 0);
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        int n;
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1;
        in_valid = 0;
        in_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_outputs", {tx_valid, tx_bit, tx_sof, tx_eof, busy}, 0);
        chk("reset_cw_count", cw_count, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("in_ready_release", in_ready, 1);
        @(posedge clk); #1;

        send(8'h00); wait_idle(); chk("frame_00", rx_last, 14'h0000);
        send(8'h10); wait_idle(); chk("frame_10", rx_last, 14'h3880);
        send(8'hFB); wait_idle(); chk("frame_FB", rx_last, 14'h3FCB);

        do_reset();
        send(8'hB1); wait_idle();
        chk("frame_B1", rx_last, 14'h25F1);
        chk("count_B1", cw_count, 2);

        mode = 1;
        send(8'hB1); wait_idle();
        chk("frame_B1_stall", rx_last, 14'h25F1);
        mode = 0;

        in_data = 8'hB1;
        in_valid = 1;
        for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
        @(posedge clk); #1;
        in_data = 8'h00;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!tx_valid) break;
            n++;
            if (in_ready && in_valid) begin
                chk("b2b_ready_on_eof", {tx_eof, n == 14}, 2'b11);
                @(posedge clk); #1;
                in_valid = 0;
            end
        end
        chk("b2b_length", n, 28);
        wait_idle();
        chk("frame_b2b_00", rx_last, 14'h0000);

        send(8'hB1);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1;
        #1;
        chk("midreset_valid", {tx_valid, tx_sof, tx_eof, busy}, 0);
        chk("midreset_count", cw_count, 0);
        @(posedge clk); #1;
        rst = 0;
        send(8'h00); wait_idle();
        chk("frame_after_reset", rx_last, 14'h0000);
        chk("count_after_reset", cw_count, 2);

        do_reset();
        mode = 2;
        for (int i = 0; i < 1500; i++) send(8'($urandom));
        wait_idle();
        mode = 0;

        do_reset();
        for (int i = 0; i < 8; i++) send(8'($urandom));
        wait_idle();
        chk("count_wrap", cw_count, 0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
